// File: rtl/set_assoc_cache.sv
// set_assoc_cache: set-associative write-back cache with true-LRU replacement.
// The hit path is combinational and takes zero cycles. A miss walks
// WRITEBACK (only if the victim is dirty), then REFILL_REQ, then REFILL_WAIT,
// and returns to IDLE. In IDLE the held request then hits.
// Optional build macro CACHE_STATS_EN adds the saturating outputs
// hit_count and miss_count.
module set_assoc_cache #(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 4,
   parameter int NUM_WAYS  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            addr,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   mem_req_valid,
   output logic                   mem_req_write,
   output logic [31:0]            mem_req_addr,
   output logic [LINE_SIZE*8-1:0] mem_req_data,
   input  logic                   mem_ready,
   input  logic                   mem_resp_valid,
   input  logic [LINE_SIZE*8-1:0] mem_resp_data
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
`endif
);
   localparam int LB  = LINE_SIZE * 8;
   localparam int WPL = LINE_SIZE / 4;
   localparam int OB  = $clog2(LINE_SIZE);
   localparam int SB  = $clog2(NUM_SETS);
   localparam int TW  = 32 - OB - SB;
   localparam int SX  = (SB > 0) ? SB : 1;
   localparam int AW  = $clog2(NUM_WAYS);
   localparam int WX  = (AW > 0) ? AW : 1;
   localparam int OX  = (WPL > 1) ? $clog2(WPL) : 1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT} state_t;

   typedef struct packed {
      logic          valid;
      logic          write;
      logic [31:0]   addr;
      logic [LB-1:0] data;
   } mem_req_t;

   state_t          state;
   mem_req_t        mreq;
   logic [WX-1:0]   victim_q;

   logic [LB-1:0]       data_q  [NUM_SETS][NUM_WAYS];
   logic [TW-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

   // address decode
   logic [SX-1:0] set_idx;
   logic [OX-1:0] word_idx;
   logic [TW-1:0] req_tag;
   logic [31:0]   line_addr;
   logic [31:0]   wb_addr;
   logic          req;
   logic          unused;

   assign req_tag   = addr[31 -: TW];
   assign line_addr = {addr[31:OB], {OB{1'b0}}};
   assign req       = mem_read | mem_write;
   assign unused    = ^addr[1:0];

   generate
      if (SB > 0) begin : g_set
         assign set_idx = addr[OB +: SB];
      end else begin : g_noset
         assign set_idx = '0;
      end
      if (WPL > 1) begin : g_word
         assign word_idx = addr[2 +: OX];
      end else begin : g_noword
         assign word_idx = '0;
      end
   endgenerate

   // tag compare across the indexed set
   logic          hit_any;
   logic [WX-1:0] hit_way;
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
            hit_any = 1'b1;
            hit_way = WX'(w);
         end
   end

   // victim choice: the lowest invalid way wins; otherwise the LRU way
   logic [WX-1:0] oldest;
   logic [WX-1:0] victim;
   always_comb begin
      victim = oldest;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_q[set_idx][w]) victim = WX'(w);
   end

   assign wb_addr = (32'(tag_q[set_idx][victim]) << (OB + SB)) | (32'(set_idx) << OB);

   // A hit or an install makes that way MRU
   logic          lru_touch;
   logic [WX-1:0] lru_way;
   assign lru_touch = (state == IDLE && req && hit_any) ||
                      (state == REFILL_WAIT && mem_resp_valid);
   assign lru_way   = (state == REFILL_WAIT) ? victim_q : hit_way;

   generate
      if (NUM_WAYS > 1) begin : g_lru
         logic [AW-1:0] age_q [NUM_SETS][NUM_WAYS];

         // the way with the maximum age is the least recently used
         always_comb begin
            oldest = '0;
            for (int w = 0; w < NUM_WAYS; w++)
               if (age_q[set_idx][w] == AW'(NUM_WAYS - 1)) oldest = WX'(w);
         end

         // the touched way gets age 0; younger ways each age by one
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int s = 0; s < NUM_SETS; s++)
                  for (int w = 0; w < NUM_WAYS; w++)
                     age_q[s][w] <= AW'(w);
            end else if (lru_touch) begin
               for (int w = 0; w < NUM_WAYS; w++)
                  if (WX'(w) == lru_way)
                     age_q[set_idx][w] <= '0;
                  else if (age_q[set_idx][w] < age_q[set_idx][lru_way])
                     age_q[set_idx][w] <= age_q[set_idx][w] + AW'(1);
            end
         end
      end else begin : g_dm
         logic unused_lru;
         assign unused_lru = lru_touch ^ (^lru_way);
         assign oldest     = '0;
      end
   endgenerate

   // control FSM: miss sequencing, valid/dirty state and the registered memory request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         victim_q <= '0;
         mreq     <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (hit_any) begin
                     if (mem_write) dirty_q[set_idx][hit_way] <= 1'b1;
                  end else begin
                     victim_q <= victim;
                     if (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) begin
                        state      <= WRITEBACK;
                        mreq.valid <= 1'b1;
                        mreq.write <= 1'b1;
                        mreq.addr  <= wb_addr;
                        mreq.data  <= data_q[set_idx][victim];
                     end else begin
                        state      <= REFILL_REQ;
                        mreq.valid <= 1'b1;
                        mreq.write <= 1'b0;
                        mreq.addr  <= line_addr;
                        mreq.data  <= '0;
                     end
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  dirty_q[set_idx][victim_q] <= 1'b0;
                  state      <= REFILL_REQ;
                  mreq.write <= 1'b0;
                  mreq.addr  <= line_addr;
                  mreq.data  <= '0;
               end
            end
            REFILL_REQ: begin
               if (mem_ready) begin
                  state      <= REFILL_WAIT;
                  mreq.valid <= 1'b0;
               end
            end
            REFILL_WAIT: begin
               if (mem_resp_valid) begin
                  valid_q[set_idx][victim_q] <= 1'b1;
                  dirty_q[set_idx][victim_q] <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // line storage: write-hit word merge and refill install (contents survive reset)
   always_ff @(posedge clk) begin
      if (state == IDLE && req && hit_any && mem_write)
         data_q[set_idx][hit_way][32*word_idx +: 32] <= din;
      if (state == REFILL_WAIT && mem_resp_valid) begin
         data_q[set_idx][victim_q] <= mem_resp_data;
         tag_q[set_idx][victim_q]  <= req_tag;
      end
   end

   assign is_ready        = (state == IDLE);
   assign is_hit          = reset && is_ready && req && hit_any;
   assign is_output_valid = is_hit;
   assign dout            = is_hit ? data_q[set_idx][hit_way][32*word_idx +: 32] : '0;

   assign mem_req_valid = mreq.valid;
   assign mem_req_write = mreq.write;
   assign mem_req_addr  = mreq.addr;
   assign mem_req_data  = mreq.data;

`ifdef CACHE_STATS_EN
   // one count per IDLE lookup; both counters saturate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && req) begin
         if (hit_any) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed sequences plus random traffic, checked every
// cycle against a line-level cache model with timestamp LRU and a word memory.
`timescale 1ns/1ps
module tb_set_assoc_cache;
   localparam int NS  = 4;
   localparam int NW  = 2;
   localparam int WPL = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  addr;
   logic         mem_read, mem_write;
   logic [31:0]  din;
   logic         is_ready, is_output_valid, is_hit;
   logic [31:0]  dout;
   logic         mem_req_valid, mem_req_write;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_data;
   logic         mem_ready, mem_resp_valid;
   logic [127:0] mem_resp_data;
`ifdef CACHE_STATS_EN
   logic [31:0]  hit_count, miss_count;
`endif

   set_assoc_cache #(.LINE_SIZE(16), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
      .clk(clk), .reset(reset), .addr(addr), .mem_read(mem_read), .mem_write(mem_write),
      .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout),
      .is_hit(is_hit), .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_ready(mem_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { bit w; bit [31:0] a; bit [127:0] d; } xfer_t;

   bit        mv   [NS][NW];
   bit        md   [NS][NW];
   bit [31:0] mla  [NS][NW];
   bit [31:0] mdat [NS][NW][WPL];
   longint    lu   [NS][NW];
   longint    stamp = 0;
   bit [31:0] mem  [bit [31:0]];
   xfer_t     expq [$];
   bit        m_busy, m_wait;
   int        m_vic, m_set;
   bit [31:0] m_line;
   int        m_hits, m_miss;

   function automatic bit [31:0] memword(input bit [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a * 32'h9E3779B1 + 32'h01234567;
   endfunction

   function automatic int set_of(input bit [31:0] a);
      return int'((a >> 4) & 3);
   endfunction

   function automatic int word_of(input bit [31:0] a);
      return int'((a >> 2) & 3);
   endfunction

   function automatic int find(input bit [31:0] a);
      int s = set_of(a);
      for (int w = 0; w < NW; w++)
         if (mv[s][w] && mla[s][w] == (a & ~32'hF)) return w;
      return -1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            mv[s][w] = 0; md[s][w] = 0; lu[s][w] = -w;
         end
      expq.delete();
      m_busy = 0; m_wait = 0; m_hits = 0; m_miss = 0;
   endtask

   task automatic model_step();
      int s, w, v;
      xfer_t x;
      bit [127:0] line;
      if (!m_busy) begin
         if (mem_read || mem_write) begin
            s = set_of(addr);
            w = find(addr);
            if (w >= 0) begin
               m_hits++;
               stamp++; lu[s][w] = stamp;
               if (mem_write) begin
                  mdat[s][w][word_of(addr)] = din;
                  md[s][w] = 1;
               end
            end else begin
               m_miss++;
               v = -1;
               for (int k = NW - 1; k >= 0; k--) if (!mv[s][k]) v = k;
               if (v < 0) begin
                  v = 0;
                  for (int k = 1; k < NW; k++) if (lu[s][k] < lu[s][v]) v = k;
               end
               if (mv[s][v] && md[s][v]) begin
                  for (int k = 0; k < WPL; k++) line[k*32 +: 32] = mdat[s][v][k];
                  x.w = 1; x.a = mla[s][v]; x.d = line;
                  expq.push_back(x);
               end
               x.w = 0; x.a = addr & ~32'hF; x.d = '0;
               expq.push_back(x);
               m_busy = 1; m_vic = v; m_set = s; m_line = addr & ~32'hF;
            end
         end
      end else if (m_wait) begin
         if (mem_resp_valid) begin
            mv[m_set][m_vic]  = 1;
            md[m_set][m_vic]  = 0;
            mla[m_set][m_vic] = m_line;
            for (int k = 0; k < WPL; k++) mdat[m_set][m_vic][k] = memword(m_line + 4*k);
            stamp++; lu[m_set][m_vic] = stamp;
            m_wait = 0; m_busy = 0;
         end
      end else if (expq.size() > 0 && mem_ready) begin
         x = expq.pop_front();
         if (x.w) for (int k = 0; k < WPL; k++) mem[x.a + 4*k] = x.d[k*32 +: 32];
         else m_wait = 1;
      end
   endtask

   always @(posedge clk) if (reset === 1'b1) model_step();

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int w;
      bit h;
      if (reset === 1'b1) begin
         chk("ready", is_ready, !m_busy);
         if (!m_busy) begin
            w = find(addr);
            h = (mem_read || mem_write) && (w >= 0);
            chk("hit", is_hit, h);
            chk("ovalid", is_output_valid, h);
            if (h && !mem_write) chk("dout", dout, mdat[set_of(addr)][w][word_of(addr)]);
            chk("req_idle", mem_req_valid, 0);
         end else begin
            chk("hit_busy", is_hit, 0);
            chk("ovalid_busy", is_output_valid, 0);
            if (expq.size() > 0) begin
               chk("req_valid", mem_req_valid, 1);
               chk("req_write", mem_req_write, expq[0].w);
               chk("req_addr", mem_req_addr, expq[0].a);
               if (expq[0].w) chk("req_data", mem_req_data, expq[0].d);
            end else begin
               chk("req_wait", mem_req_valid, 0);
            end
         end
`ifdef CACHE_STATS_EN
         chk("hit_count", hit_count, m_hits);
         chk("miss_count", miss_count, m_miss);
`endif
      end
   end

   // ---------------- backing memory responder ----------------
   int ready_mode;   // 0 random, 1 always ready, 2 stalled
   bit resp_hold, spur_force, was_wait;
   int rdly;

   always @(posedge clk) begin
      #2;
      if (m_wait && !was_wait) rdly = $urandom_range(0, 3);
      was_wait = m_wait;
      case (ready_mode)
         0:       mem_ready = ($urandom_range(0, 3) != 0);
         1:       mem_ready = 1'b1;
         default: mem_ready = 1'b0;
      endcase
      if (m_wait && !resp_hold) begin
         if (rdly > 0) begin
            rdly--;
            mem_resp_valid = 1'b0;
         end else begin
            mem_resp_valid = 1'b1;
            for (int k = 0; k < WPL; k++) mem_resp_data[k*32 +: 32] = memword(m_line + 4*k);
         end
      end else if (spur_force || (ready_mode == 0 && !m_wait && $urandom_range(0, 7) == 0)) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
         mem_resp_valid = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit [31:0] a, input bit rd, input bit wr, input bit [31:0] d);
      addr = a; mem_read = rd; mem_write = wr; din = d;
   endtask

   // hold the request until the model is idle, then clock the retry hit
   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (m_busy) begin
         bad++;
         $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
      end
      tick();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      set_req(0, 0, 0, 0);
      mem_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
      ready_mode = 1; resp_hold = 0; spur_force = 0; was_wait = 0; rdly = 0;
      mem[32'h44] = 32'h11223344;
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", is_ready, 1);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_write", mem_req_write, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_hit", is_hit, 0);
      chk("rst_ovalid", is_output_valid, 0);
      chk("rst_dout", dout, 0);
      reset = 1'b1;
      tick();

      // cold miss on 0x40, refill, then a zero-latency hit on 0x44
      set_req(32'h40, 1, 0, 0);
      #1 chk("cold_hit", is_hit, 0);
      tick(); #2;
      chk("refill_valid", mem_req_valid, 1);
      chk("refill_write", mem_req_write, 0);
      chk("refill_addr", mem_req_addr, 32'h40);
      chk("refill_busy", is_ready, 0);
      wait_idle();
      set_req(32'h44, 1, 0, 0);
      #1;
      chk("rd44_hit", is_hit, 1);
      chk("rd44_dout", dout, 32'h11223344);
      tick();
`ifdef CACHE_STATS_EN
      chk("stat_hits", hit_count, 2);
      chk("stat_miss", miss_count, 1);
`endif

      // write hit 0x44 then read it back
      set_req(32'h44, 0, 1, 32'hDEADBEEF);
      #1;
      chk("wr44_ovalid", is_output_valid, 1);
      chk("wr44_noreq", mem_req_valid, 0);
      tick();
      set_req(32'h44, 1, 0, 0);
      #1 chk("rd44_new", dout, 32'hDEADBEEF);
      tick();

      // fill way 1 with 0x00, then 0x80 evicts dirty 0x40
      set_req(32'h00, 1, 0, 0);
      #1 chk("rd00_miss", is_hit, 0);
      tick();
      wait_idle();
      ready_mode = 2;
      set_req(32'h80, 1, 0, 0);
      #1 chk("rd80_miss", is_hit, 0);
      tick(); #2;
      chk("wb_valid", mem_req_valid, 1);
      chk("wb_write", mem_req_write, 1);
      chk("wb_addr", mem_req_addr, 32'h40);
      chk("wb_word1", mem_req_data[63:32], 32'hDEADBEEF);
      ready_mode = 1;
      n = 0;
      while (expq.size() > 0 && expq[0].w && n < 20) begin
         tick();
         n++;
      end
      ready_mode = 2;
      #2;
      chk("rf80_addr", mem_req_addr, 32'h80);
      chk("rf80_write", mem_req_write, 0);
      for (int i = 0; i < 10; i++) begin
         tick(); #2;
         chk("stall_valid", mem_req_valid, 1);
         chk("stall_addr", mem_req_addr, 32'h80);
         chk("stall_ready", is_ready, 0);
      end
      ready_mode = 1;
      wait_idle();
      set_req(32'h00, 1, 0, 0);
      #1 chk("keep00", is_hit, 1);
      tick();

      // reset while waiting for the refill response
      resp_hold = 1;
      set_req(32'h40, 1, 0, 0);
      n = 0;
      while (!m_wait && n < 20) begin
         tick();
         n++;
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("arst_req_valid", mem_req_valid, 0);
      chk("arst_ready", is_ready, 1);
      chk("arst_req_addr", mem_req_addr, 0);
      set_req(0, 0, 0, 0);
      resp_hold = 0;
      spur_force = 1;
      tick();
      reset = 1'b1;
      tick();
      tick();
      spur_force = 0;
      set_req(32'h40, 1, 0, 0);
      #1 chk("post_rst_miss", is_hit, 0);
      tick();
      wait_idle();

      // random traffic
      ready_mode = 0;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 7);
         set_req(($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2),
                 (r >= 1 && r <= 4) || r == 7, r >= 5, $urandom());
         tick();
         if (m_busy) wait_idle();
      end
      set_req(0, 0, 0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
